// File: rtl/complex_fir_pkg.sv
// Shared definitions for the complex FIR coefficient path: FSM encoding,
// default sizing and the complex coefficient type.
package complex_fir_pkg;

  localparam int DEF_LENGTH      = 20;
  localparam int DEF_DATA_WIDTH  = 18;
  localparam int DEF_COUNT_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } coeff_t;

endpackage

// File: rtl/complex_coeff_bank.sv
// LENGTH-deep complex tap register bank: one write port, one registered read
// port that returns zero for out-of-range indices, synchronous clear.
module complex_coeff_bank #(
  parameter int LENGTH      = 20,
  parameter int DATA_WIDTH  = 18,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [COUNT_WIDTH-1:0]  waddr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  input  logic [COUNT_WIDTH-1:0]  raddr,
  output logic [2*DATA_WIDTH-1:0] rdata
);

  logic [2*DATA_WIDTH-1:0] mem_q [LENGTH];
  logic [2*DATA_WIDTH-1:0] mem_d [LENGTH];
  logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Compare-per-entry decode keeps index widths independent of LENGTH and
  // makes any address >= LENGTH a natural no-op / zero read.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    for (int i = 0; i < LENGTH; i++) begin
      if (we && waddr == COUNT_WIDTH'(i)) mem_d[i] = wdata;
      if (raddr == COUNT_WIDTH'(i)) rdata_d = mem_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LENGTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/complex_fir_coeff_loader.sv
// Captures a serial stream of complex coefficients into the tap bank and
// reports load progress, completion and overrun for the FIR datapath.
//
// state   | meaning
// IDLE    | no load in progress, bank contents not a complete set
// LOAD    | accepting one coefficient per valid cycle
// DONE    | bank holds LENGTH coefficients; further valids are overruns
module complex_fir_coeff_loader
  import complex_fir_pkg::*;
#(
  parameter int LENGTH      = DEF_LENGTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          loadStart,
  input  logic                          coeffInValid,
  input  logic signed [DATA_WIDTH-1:0]  coeffInRe,
  input  logic signed [DATA_WIDTH-1:0]  coeffInIm,
  input  logic        [COUNT_WIDTH-1:0] tapIndex,
  output logic signed [DATA_WIDTH-1:0]  tapRe,
  output logic signed [DATA_WIDTH-1:0]  tapIm,
  output logic                          coeffsLoaded,
  output logic                          loading,
  output logic        [COUNT_WIDTH-1:0] loadCount,
  output logic                          loadError
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(LENGTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(LENGTH);

  load_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0] windex_q, windex_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   error_q, error_d;
  logic                   bank_we;
  logic [2*DATA_WIDTH-1:0] bank_rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      windex_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      windex_q <= windex_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    windex_d = windex_q;
    count_d  = count_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (loadStart) begin
          state_d  = ST_LOAD;
          windex_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        // A restart wins over a coincident valid; that sample is dropped.
        if (loadStart) begin
          windex_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end else if (coeffInValid) begin
          if (windex_q == LAST_IDX) begin
            state_d  = ST_DONE;
            windex_d = '0;
            count_d  = FULL_CNT;
          end else begin
            windex_d = windex_q + COUNT_WIDTH'(1);
            count_d  = count_q + COUNT_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        if (loadStart) begin
          state_d  = ST_LOAD;
          windex_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end else if (coeffInValid) begin
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    loading      = 1'b0;
    coeffsLoaded = 1'b0;
    bank_we      = 1'b0;
    case (state_q)
      ST_LOAD: begin
        loading = 1'b1;
        bank_we = coeffInValid && !loadStart;
      end
      ST_DONE: coeffsLoaded = 1'b1;
      default: ;
    endcase
  end

  assign loadCount = count_q;
  assign loadError = error_q;

  complex_coeff_bank #(
    .LENGTH      (LENGTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bank (
    .clock (clock),
    .reset (reset),
    .we    (bank_we),
    .waddr (windex_q),
    .wdata ({coeffInRe, coeffInIm}),
    .raddr (tapIndex),
    .rdata (bank_rdata)
  );

  assign tapRe = bank_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign tapIm = bank_rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_complex_fir_coeff_loader.sv
// Self-checking bench: directed load scenarios plus randomized traffic
// against a behavioural model of the coefficient loader.
module tb_complex_fir_coeff_loader;

  localparam int LENGTH = 20;
  localparam int DW     = 18;
  localparam int CW     = 10;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  loadStart;
  logic                  coeffInValid;
  logic signed [DW-1:0]  coeffInRe;
  logic signed [DW-1:0]  coeffInIm;
  logic        [CW-1:0]  tapIndex;
  logic signed [DW-1:0]  tapRe;
  logic signed [DW-1:0]  tapIm;
  logic                  coeffsLoaded;
  logic                  loading;
  logic        [CW-1:0]  loadCount;
  logic                  loadError;

  complex_fir_coeff_loader #(
    .LENGTH      (LENGTH),
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .loadStart    (loadStart),
    .coeffInValid (coeffInValid),
    .coeffInRe    (coeffInRe),
    .coeffInIm    (coeffInIm),
    .tapIndex     (tapIndex),
    .tapRe        (tapRe),
    .tapIm        (tapIm),
    .coeffsLoaded (coeffsLoaded),
    .loading      (loading),
    .loadCount    (loadCount),
    .loadError    (loadError)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference: the bank as plain integers, plus "is a load running",
  // "is a full set present", how many stored so far, and the overrun flag.
  int m_re [LENGTH];
  int m_im [LENGTH];
  bit m_loading, m_full, m_err;
  int m_count;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s1_re(input int i);
    if (i == 0) return 34124;
    if (i == 19) return 10000;
    return i * 1111 - 9000;
  endfunction

  function automatic int s1_im(input int i);
    if (i == 0) return -7392;
    if (i == 19) return 1;
    return 50 - i * 333;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LENGTH; i++) begin
      m_re[i] = 0;
      m_im[i] = 0;
    end
    m_loading = 0;
    m_full    = 0;
    m_err     = 0;
    m_count   = 0;
  endtask

  task automatic cycle(input bit rst_n, input bit ls, input bit v,
                       input int re, input int im, input int tidx);
    int exp_re, exp_im;
    reset        = rst_n;
    loadStart    = ls;
    coeffInValid = v;
    coeffInRe    = DW'(re);
    coeffInIm    = DW'(im);
    tapIndex     = CW'(tidx);
    exp_re = (tidx < LENGTH) ? m_re[tidx] : 0;
    exp_im = (tidx < LENGTH) ? m_im[tidx] : 0;
    if (!rst_n) begin
      model_reset();
      exp_re = 0;
      exp_im = 0;
    end else if (m_loading) begin
      if (ls) begin
        m_count = 0;
        m_err   = 0;
      end else if (v) begin
        m_re[m_count] = re;
        m_im[m_count] = im;
        m_count++;
        if (m_count == LENGTH) begin
          m_loading = 0;
          m_full    = 1;
        end
      end
    end else if (m_full) begin
      if (ls) begin
        m_full    = 0;
        m_loading = 1;
        m_count   = 0;
        m_err     = 0;
      end else if (v) begin
        m_err = 1;
      end
    end else if (ls) begin
      m_loading = 1;
      m_count   = 0;
      m_err     = 0;
    end
    @(posedge clock);
    #1;
    check_eq("tapRe", int'(tapRe), exp_re);
    check_eq("tapIm", int'(tapIm), exp_im);
    check_eq("coeffsLoaded", int'(coeffsLoaded), int'(m_full));
    check_eq("loading", int'(loading), int'(m_loading));
    check_eq("loadCount", int'(loadCount), m_count);
    check_eq("loadError", int'(loadError), int'(m_err));
  endtask

  task automatic idle(input int tidx);
    cycle(1, 0, 0, 0, 0, tidx);
  endtask

  initial begin
    model_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check_eq("rst_count", int'(loadCount), 0);

    // 1: plain load of 20 coefficients
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < LENGTH; i++) cycle(1, 0, 1, s1_re(i), s1_im(i), 0);
    check_eq("s1_loaded", int'(coeffsLoaded), 1);
    check_eq("s1_count", int'(loadCount), 20);
    idle(0);
    check_eq("s1_tap0_re", int'(tapRe), 34124);
    check_eq("s1_tap0_im", int'(tapIm), -7392);
    idle(19);
    check_eq("s1_tap19_re", int'(tapRe), 10000);
    check_eq("s1_tap19_im", int'(tapIm), 1);

    // 2: same set with gaps between samples 5 and 6
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < LENGTH; i++) begin
      cycle(1, 0, 1, s1_re(i), s1_im(i), i);
      if (i == 5) for (int g = 0; g < 4; g++) idle(g);
    end
    idle(0);
    check_eq("s2_tap0_re", int'(tapRe), 34124);

    // 3: restart after 7 samples with a valid on the restart cycle
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 1, i + 500, -i, 0);
    cycle(1, 1, 1, 999, 999, 0);
    check_eq("s3_restart_count", int'(loadCount), 0);
    for (int i = 0; i < LENGTH; i++) cycle(1, 0, 1, 200 + i, -300 - i, 0);
    for (int i = 0; i < LENGTH; i++) idle(i);

    // 4: overrun in DONE, then cleared by a new load
    cycle(1, 0, 1, 1, 1, 0);
    check_eq("s4_err", int'(loadError), 1);
    idle(0);
    check_eq("s4_tap0_re", int'(tapRe), 200);
    check_eq("s4_loaded", int'(coeffsLoaded), 1);
    cycle(1, 1, 0, 0, 0, 0);
    check_eq("s4_err_clr", int'(loadError), 0);

    // 5: reset after 10 samples
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 7 * i + 3, 11 - i, 0);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LENGTH; i++) idle(i);

    // 6: out-of-range reads on a loaded bank
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < LENGTH; i++) cycle(1, 0, 1, s1_re(i), s1_im(i), 0);
    idle(20);
    check_eq("s6_oor20_re", int'(tapRe), 0);
    idle(1023);
    check_eq("s6_oor1023_im", int'(tapIm), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit rst_n, ls, v;
      int tidx;
      rst_n = ($urandom_range(0, 399) != 0);
      ls    = ($urandom_range(0, 29) == 0);
      v     = ($urandom_range(0, 9) < 6);
      tidx  = ($urandom_range(0, 15) == 0) ? 1023 : int'($urandom_range(0, 24));
      cycle(rst_n, ls, v, int'($urandom_range(0, 262143)) - 131072,
            int'($urandom_range(0, 262143)) - 131072, tidx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
